// File: rtl/pass_sched_ctrl.sv
// Layer-level pass scheduler: walks one convolution layer as a set of passes
// over input-channel groups (inner loop) and output-channel groups (outer
// loop). Each pass runs the GLB loaders, then PE compute, then psum store.
// Every output is registered.
module pass_sched_ctrl #(
  parameter int W_PASS_CNT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [9:0]            i_layer_C,
  input  logic [8:0]            i_layer_M,
  input  logic [2:0]            i_layer_p,
  input  logic [2:0]            i_layer_q,
  input  logic [1:0]            i_layer_r,
  input  logic [1:0]            i_layer_t,
  output logic                  o_ifmap_start,
  input  logic                  i_ifmap_done,
  output logic                  o_filt_start,
  input  logic                  i_filt_done,
  output logic                  o_pe_start,
  input  logic                  i_pe_done,
  output logic                  o_psum_start,
  input  logic                  i_psum_done,
  output logic [9:0]            o_c_base,
  output logic [8:0]            o_m_base,
  output logic                  o_first_cpass,
  output logic                  o_last_cpass,
  output logic                  o_busy,
  output logic                  o_layer_done,
  output logic                  o_cfg_err,
  output logic [W_PASS_CNT-1:0] o_pass_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    STORE   = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state, state_d;

  // Latched layer geometry and per-pass group steps
  logic [9:0] c_lim, c_lim_d;
  logic [8:0] m_lim, m_lim_d;
  logic [4:0] cstep, cstep_d;
  logic [4:0] mstep, mstep_d;
  logic       err, err_d;

  // Sticky loader-done flags for the current LOAD phase
  logic ifmap_ok, ifmap_ok_d;
  logic filt_ok, filt_ok_d;
  logic ifmap_now, filt_now;

  // Next values of the registered outputs
  logic                  ifmap_start_d, filt_start_d, pe_start_d, psum_start_d;
  logic [9:0]            c_base_d;
  logic [8:0]            m_base_d;
  logic                  first_d, last_d, busy_d, layer_done_d, cfg_err_d;
  logic [W_PASS_CNT-1:0] pass_cnt_d;

  // Widened sums so base+step never wraps before the limit compare
  logic [10:0] c_sum;
  logic [9:0]  m_sum;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state, datapath and output-pulse decode
  always_comb begin
    state_d       = state;
    c_lim_d       = c_lim;
    m_lim_d       = m_lim;
    cstep_d       = cstep;
    mstep_d       = mstep;
    err_d         = err;
    ifmap_ok_d    = ifmap_ok;
    filt_ok_d     = filt_ok;
    ifmap_start_d = 1'b0;
    filt_start_d  = 1'b0;
    pe_start_d    = 1'b0;
    psum_start_d  = 1'b0;
    layer_done_d  = 1'b0;
    cfg_err_d     = 1'b0;
    c_base_d      = o_c_base;
    m_base_d      = o_m_base;
    pass_cnt_d    = o_pass_cnt;
    c_sum         = {1'b0, o_c_base} + {6'b0, cstep};
    m_sum         = {1'b0, o_m_base} + {5'b0, mstep};
    // A done seen in the same cycle as its start pulse belongs to nothing
    ifmap_now     = ifmap_ok | (i_ifmap_done & ~o_ifmap_start);
    filt_now      = filt_ok  | (i_filt_done  & ~o_filt_start);

    case (state)
      IDLE: begin
        if (i_start) begin
          c_lim_d    = i_layer_C;
          m_lim_d    = i_layer_M;
          cstep_d    = {2'b0, i_layer_q} * {3'b0, i_layer_r};
          mstep_d    = {2'b0, i_layer_p} * {3'b0, i_layer_t};
          c_base_d   = '0;
          m_base_d   = '0;
          pass_cnt_d = '0;
          ifmap_ok_d = 1'b0;
          filt_ok_d  = 1'b0;
          if (cstep_d == 5'd0 || mstep_d == 5'd0) begin
            // A zero step would never terminate: reject without any starts
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d         = 1'b0;
            state_d       = LOAD;
            ifmap_start_d = 1'b1;
            filt_start_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ifmap_now && filt_now) begin
          state_d    = COMPUTE;
          pe_start_d = 1'b1;
          ifmap_ok_d = 1'b0;
          filt_ok_d  = 1'b0;
        end else begin
          ifmap_ok_d = ifmap_now;
          filt_ok_d  = filt_now;
        end
      end
      COMPUTE: begin
        if (i_pe_done && !o_pe_start) begin
          state_d      = STORE;
          psum_start_d = 1'b1;
        end
      end
      STORE: begin
        if (i_psum_done && !o_psum_start) begin
          state_d = NEXT;
          if (o_pass_cnt != '1)
            pass_cnt_d = o_pass_cnt + {{(W_PASS_CNT-1){1'b0}}, 1'b1};
        end
      end
      NEXT: begin
        if (c_sum < {1'b0, c_lim}) begin
          c_base_d      = c_sum[9:0];
          state_d       = LOAD;
          ifmap_start_d = 1'b1;
          filt_start_d  = 1'b1;
        end else begin
          c_base_d = '0;
          if (m_sum < {1'b0, m_lim}) begin
            m_base_d      = m_sum[8:0];
            state_d       = LOAD;
            ifmap_start_d = 1'b1;
            filt_start_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        layer_done_d = 1'b1;
        cfg_err_d    = err;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pass flags follow the base they describe
    first_d = (c_base_d == 10'd0);
    last_d  = (({1'b0, c_base_d} + {6'b0, cstep_d}) >= {1'b0, c_lim_d});
    busy_d  = (state_d != IDLE);
  end

  // Registered datapath and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c_lim         <= '0;
      m_lim         <= '0;
      cstep         <= '0;
      mstep         <= '0;
      err           <= 1'b0;
      ifmap_ok      <= 1'b0;
      filt_ok       <= 1'b0;
      o_ifmap_start <= 1'b0;
      o_filt_start  <= 1'b0;
      o_pe_start    <= 1'b0;
      o_psum_start  <= 1'b0;
      o_c_base      <= '0;
      o_m_base      <= '0;
      o_first_cpass <= 1'b0;
      o_last_cpass  <= 1'b0;
      o_busy        <= 1'b0;
      o_layer_done  <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_pass_cnt    <= '0;
    end else begin
      c_lim         <= c_lim_d;
      m_lim         <= m_lim_d;
      cstep         <= cstep_d;
      mstep         <= mstep_d;
      err           <= err_d;
      ifmap_ok      <= ifmap_ok_d;
      filt_ok       <= filt_ok_d;
      o_ifmap_start <= ifmap_start_d;
      o_filt_start  <= filt_start_d;
      o_pe_start    <= pe_start_d;
      o_psum_start  <= psum_start_d;
      o_c_base      <= c_base_d;
      o_m_base      <= m_base_d;
      o_first_cpass <= first_d;
      o_last_cpass  <= last_d;
      o_busy        <= busy_d;
      o_layer_done  <= layer_done_d;
      o_cfg_err     <= cfg_err_d;
      o_pass_cnt    <= pass_cnt_d;
    end
  end

endmodule

// File: tb/tb_pass_sched_ctrl.sv
// Bench for pass_sched_ctrl: a table of layer configurations, each run with
// an in-line done responder and a pass-by-pass model of the channel bases.
module tb_pass_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  layer_C;
  logic [8:0]  layer_M;
  logic [2:0]  layer_p, layer_q;
  logic [1:0]  layer_r, layer_t;
  logic        ifmap_start, ifmap_done, filt_start, filt_done;
  logic        pe_start, pe_done, psum_start, psum_done;
  logic [9:0]  c_base;
  logic [8:0]  m_base;
  logic        first_cpass, last_cpass, busy, layer_done, cfg_err;
  logic [15:0] pass_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pass_sched_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_layer_C(layer_C), .i_layer_M(layer_M),
    .i_layer_p(layer_p), .i_layer_q(layer_q),
    .i_layer_r(layer_r), .i_layer_t(layer_t),
    .o_ifmap_start(ifmap_start), .i_ifmap_done(ifmap_done),
    .o_filt_start(filt_start), .i_filt_done(filt_done),
    .o_pe_start(pe_start), .i_pe_done(pe_done),
    .o_psum_start(psum_start), .i_psum_done(psum_done),
    .o_c_base(c_base), .o_m_base(m_base),
    .o_first_cpass(first_cpass), .o_last_cpass(last_cpass),
    .o_busy(busy), .o_layer_done(layer_done), .o_cfg_err(cfg_err),
    .o_pass_cnt(pass_cnt)
  );

  typedef struct {
    int C, M, p, q, r, t;
    int dif, dfi, dpe, dps;   // done delay in cycles after each start
    int stray;                // inject i_start + i_pe_done during STORE
    int abort_pass;           // assert reset at pe_start of this pass (0 = never)
    int passes, err, last_m;  // hand-computed expectations
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_layer(input vec_t v, input int idx);
    int cstep, mstep, ec, em, n_if, n_pe, cyc, t0, per;
    int ci, cf, cp, cs;
    bit gi, gf, fin, abort;
    cstep = v.q * v.r;
    mstep = v.p * v.t;
    ec = 0; em = 0; n_if = 0; n_pe = 0; cyc = 0; t0 = -1;
    ci = 0; cf = 0; cp = 0; cs = 0;
    gi = 0; gf = 0; fin = 0; abort = 0;
    per = ((v.dif > v.dfi ? v.dif : v.dfi) + 1) + (v.dpe + 1) + (v.dps + 1) + 1;
    @(negedge clk);
    layer_C = 10'(v.C); layer_M = 9'(v.M);
    layer_p = 3'(v.p);  layer_q = 3'(v.q);
    layer_r = 2'(v.r);  layer_t = 2'(v.t);
    start = 1'b1;
    for (int k = 0; k < 4000 && !fin; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ifmap_done = 1'b0; filt_done = 1'b0; pe_done = 1'b0; psum_done = 1'b0;
      if (ci > 0) begin ci--; if (ci == 0) begin ifmap_done = 1'b1; gi = 1; end end
      if (cf > 0) begin cf--; if (cf == 0) begin filt_done = 1'b1; gf = 1; end end
      if (cp > 0) begin cp--; if (cp == 0) pe_done = 1'b1; end
      if (cs > 0) begin cs--; if (cs == 0) psum_done = 1'b1; end
      if (ifmap_start) begin
        if (t0 < 0) t0 = cyc;
        chk($sformatf("v%0d filt_start_with_ifmap", idx), filt_start, 1);
        chk($sformatf("v%0d c_base pass%0d", idx, n_if), c_base, ec);
        chk($sformatf("v%0d m_base pass%0d", idx, n_if), m_base, em);
        chk($sformatf("v%0d first_cpass pass%0d", idx, n_if), first_cpass, ec == 0);
        chk($sformatf("v%0d last_cpass pass%0d", idx, n_if), last_cpass, ec + cstep >= v.C);
        chk($sformatf("v%0d pass_cnt at load%0d", idx, n_if), pass_cnt, n_if);
        n_if++;
        ci = v.dif; cf = v.dfi;
        ec += cstep;
        if (ec >= v.C) begin ec = 0; em += mstep; end
      end
      if (pe_start) begin
        chk($sformatf("v%0d pe_start_after_both_dones", idx), {31'd0, gi & gf}, 1);
        chk($sformatf("v%0d busy_in_compute", idx), busy, 1);
        gi = 0; gf = 0;
        n_pe++;
        cp = v.dpe;
        if (v.abort_pass != 0 && n_pe == v.abort_pass) abort = 1;
      end
      if (psum_start) begin
        cs = v.dps;
        if (v.stray != 0) begin start = 1'b1; pe_done = 1'b1; end
      end
      if (cfg_err && !layer_done)
        chk($sformatf("v%0d cfg_err_without_done", idx), cfg_err, 0);
      if (abort) begin
        rst = 1'b1;
        ifmap_done = 1'b0; filt_done = 1'b0; pe_done = 1'b0; psum_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk($sformatf("v%0d outputs_after_reset", idx),
            {ifmap_start, filt_start, pe_start, psum_start, first_cpass, last_cpass,
             busy, layer_done, cfg_err, 23'd0} | {c_base, m_base, 13'd0} | {16'd0, pass_cnt}, 0);
        fin = 1;
      end else if (layer_done) begin
        chk($sformatf("v%0d cfg_err", idx), cfg_err, v.err);
        chk($sformatf("v%0d pass_cnt_final", idx), pass_cnt, v.passes);
        chk($sformatf("v%0d ifmap_starts", idx), n_if, v.passes);
        chk($sformatf("v%0d pe_starts", idx), n_pe, v.passes);
        chk($sformatf("v%0d m_base_final", idx), m_base, v.last_m);
        chk($sformatf("v%0d c_base_final", idx), c_base, 0);
        chk($sformatf("v%0d busy_at_done", idx), busy, 0);
        if (v.err != 0) chk($sformatf("v%0d err_latency", idx), cyc, 2);
        else            chk($sformatf("v%0d layer_latency", idx), cyc - t0, v.passes * per + 1);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_width", idx), {layer_done, cfg_err}, 0);
        chk($sformatf("v%0d m_base_hold", idx), m_base, v.last_m);
        chk($sformatf("v%0d pass_cnt_hold", idx), pass_cnt, v.passes);
        fin = 1;
      end
    end
    if (!fin) chk($sformatf("v%0d timeout", idx), 0, 1);
    ifmap_done = 1'b0; filt_done = 1'b0; pe_done = 1'b0; psum_done = 1'b0; start = 1'b0;
  endtask

  initial begin
    //          C   M  p q r t dif dfi dpe dps st ab passes err last_m
    tab[0] = '{64, 32, 4, 4, 2, 2, 1, 1, 1, 1, 0, 0, 32, 0, 24};
    tab[1] = '{ 3,  5, 1, 4, 1, 2, 1, 1, 1, 1, 0, 0,  3, 0,  4};
    tab[2] = '{10,  9, 1, 3, 1, 3, 6, 1, 1, 1, 0, 0, 12, 0,  6};
    tab[3] = '{10,  9, 1, 3, 1, 3, 2, 2, 3, 2, 1, 0, 12, 0,  6};
    tab[4] = '{ 8,  8, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0,  0, 1,  0};
    tab[5] = '{ 8,  8, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0,  0, 1,  0};
    tab[6] = '{64, 32, 4, 4, 2, 2, 1, 1, 1, 1, 0, 3,  0, 0,  0};
    tab[7] = '{16,  4, 2, 3, 3, 1, 1, 2, 1, 1, 0, 0,  4, 0,  2};

    rst = 1'b1; start = 1'b0;
    layer_C = '0; layer_M = '0; layer_p = '0; layer_q = '0; layer_r = '0; layer_t = '0;
    ifmap_done = 1'b0; filt_done = 1'b0; pe_done = 1'b0; psum_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {ifmap_start, filt_start, pe_start, psum_start, layer_done, cfg_err}, 0);
    chk("reset_bases", {c_base, m_base}, 0);
    chk("reset_pass_cnt", pass_cnt, 0);
    chk("reset_flags", {first_cpass, last_cpass}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_layer(tab[i], i);

    // Done pulses while idle must not start anything
    @(negedge clk);
    ifmap_done = 1'b1; filt_done = 1'b1; pe_done = 1'b1; psum_done = 1'b1;
    @(negedge clk);
    ifmap_done = 1'b0; filt_done = 1'b0; pe_done = 1'b0; psum_done = 1'b0;
    @(negedge clk);
    chk("idle_ignores_done", {busy, ifmap_start, pe_start, psum_start}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
